// File: rtl/sd_pkg.sv
// Shared SD identification constants, enums and the per-step command table.
package sd_pkg;

    localparam logic [5:0] CMD0   = 6'd0;
    localparam logic [5:0] CMD2   = 6'd2;
    localparam logic [5:0] CMD3   = 6'd3;
    localparam logic [5:0] CMD7   = 6'd7;
    localparam logic [5:0] CMD8   = 6'd8;
    localparam logic [5:0] CMD16  = 6'd16;
    localparam logic [5:0] CMD55  = 6'd55;
    localparam logic [5:0] ACMD41 = 6'd41;

    localparam logic [31:0] CMD8_ARG       = 32'h0000_01AA;
    localparam logic [31:0] ACMD41_ARG_HCS = 32'h40FF_8000;
    localparam logic [31:0] ACMD41_ARG_SC  = 32'h00FF_8000;
    localparam logic [31:0] BLKLEN_ARG     = 32'd512;

    // CMD0 needs the long power-up idle run; everything else a short gap
    localparam logic [15:0] PRE_CMD0 = 16'd80;
    localparam logic [15:0] PRE_STD  = 16'd8;

    typedef enum logic [1:0] {
        CT_UNKNOWN = 2'd0,
        CT_SDV1    = 2'd1,
        CT_SDV2    = 2'd2,
        CT_SDHC    = 2'd3
    } card_type_t;

    typedef enum logic [2:0] {
        ERR_NONE         = 3'd0,
        ERR_CMD8_PATTERN = 3'd1,
        ERR_ACMD41_BUSY  = 3'd2,
        ERR_TIMEOUT      = 3'd3,
        ERR_SYNTAX       = 3'd4
    } init_err_t;

    typedef enum logic [2:0] {
        ST_CMD0, ST_CMD8, ST_CMD55, ST_ACMD41,
        ST_CMD2, ST_CMD3, ST_CMD7, ST_CMD16
    } init_step_t;

    typedef struct packed {
        logic [5:0]  idx;
        logic [31:0] arg;
        logic [15:0] pre;
    } cmd_req_t;

    // Index/argument/precycles for a given step; the argument of ACMD41
    // depends on the card type, CMD7 on the freshly assigned RCA.
    function automatic cmd_req_t step_cmd(input init_step_t s, input card_type_t t,
                                          input logic [15:0] rca);
        cmd_req_t r;
        r.idx = CMD0;
        r.arg = '0;
        r.pre = PRE_STD;
        case (s)
            ST_CMD0:   begin r.idx = CMD0; r.pre = PRE_CMD0; end
            ST_CMD8:   begin r.idx = CMD8; r.arg = CMD8_ARG; end
            ST_CMD55:  r.idx = CMD55;
            ST_ACMD41: begin
                r.idx = ACMD41;
                r.arg = (t == CT_SDV1) ? ACMD41_ARG_SC : ACMD41_ARG_HCS;
            end
            ST_CMD2:   r.idx = CMD2;
            ST_CMD3:   r.idx = CMD3;
            ST_CMD7:   begin r.idx = CMD7; r.arg = {rca, 16'h0000}; end
            ST_CMD16:  begin r.idx = CMD16; r.arg = BLKLEN_ARG; end
            default:   ;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/sd_init_seq_if.sv
// Sequencer <-> CMD-line engine handshake bundle.
interface sd_init_seq_if;
    logic        cmd_start;
    logic [15:0] cmd_precycles;
    logic [15:0] cmd_clkdiv;
    logic [5:0]  cmd_idx;
    logic [31:0] cmd_arg;
    logic [31:0] cmd_resparg;
    logic        cmd_busy;
    logic        cmd_done;
    logic        cmd_timeout;
    logic        cmd_syntaxerr;

    modport master (
        output cmd_start, cmd_precycles, cmd_clkdiv, cmd_idx, cmd_arg,
        input  cmd_resparg, cmd_busy, cmd_done, cmd_timeout, cmd_syntaxerr
    );

    modport slave (
        input  cmd_start, cmd_precycles, cmd_clkdiv, cmd_idx, cmd_arg,
        output cmd_resparg, cmd_busy, cmd_done, cmd_timeout, cmd_syntaxerr
    );
endinterface

// File: rtl/sd_init_seq.sv
// SD card identification sequencer: drives the CMD engine through
// CMD0/8/55/ACMD41/2/3/7[/16], then switches the engine to the fast divider.
module sd_init_seq
    import sd_pkg::*;
#(
    parameter logic [15:0] SLOW_CLKDIV    = 16'd150,
    parameter logic [15:0] FAST_CLKDIV    = 16'd2,
    parameter int          ACMD41_RETRIES = 1023,
    parameter int          CMD_RETRIES    = 3
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           init_start,
    sd_init_seq_if.master  cmd,
    output logic           init_busy,
    output logic           init_done,
    output logic           init_err,
    output logic [2:0]     err_code,
    output logic [5:0]     err_cmd,
    output logic [1:0]     card_type,
    output logic [15:0]    rca
);

    localparam int RW = (CMD_RETRIES < 1) ? 1 : $clog2(CMD_RETRIES + 1);
    localparam logic [RW-1:0] RETRY_MAX = RW'(CMD_RETRIES);
    localparam logic [10:0]   POLL_MAX  = 11'(ACMD41_RETRIES);

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_EVAL, S_DONE, S_ERROR} fsm_t;

    fsm_t        state_q, state_d;
    init_step_t  step_q, step_d;
    logic [RW-1:0] retry_q, retry_d;
    logic [9:0]  poll_q, poll_d;
    logic        to_q, to_d, se_q, se_d;
    logic [31:0] resp_q, resp_d;
    logic        start_q, start_d;
    logic [5:0]  idx_q, idx_d;
    logic [31:0] arg_q, arg_d;
    logic [15:0] pre_q, pre_d;
    logic [15:0] div_q, div_d;
    logic        busy_q, busy_d, done_q, done_d, err_q, err_d;
    init_err_t   ecode_q, ecode_d;
    logic [5:0]  ecmd_q, ecmd_d;
    card_type_t  ctype_q, ctype_d;
    logic [15:0] rca_q, rca_d;

    logic        load_cmd, go_err, retry_step;
    cmd_req_t    req;

    // State, counters and every output register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;   step_q  <= ST_CMD0;    retry_q <= '0;
            poll_q  <= '0;       to_q    <= 1'b0;       se_q    <= 1'b0;
            resp_q  <= '0;       start_q <= 1'b0;       idx_q   <= '0;
            arg_q   <= '0;       pre_q   <= PRE_CMD0;   div_q   <= SLOW_CLKDIV;
            busy_q  <= 1'b0;     done_q  <= 1'b0;       err_q   <= 1'b0;
            ecode_q <= ERR_NONE; ecmd_q  <= '0;         ctype_q <= CT_UNKNOWN;
            rca_q   <= '0;
        end else begin
            state_q <= state_d;  step_q  <= step_d;     retry_q <= retry_d;
            poll_q  <= poll_d;   to_q    <= to_d;       se_q    <= se_d;
            resp_q  <= resp_d;   start_q <= start_d;    idx_q   <= idx_d;
            arg_q   <= arg_d;    pre_q   <= pre_d;      div_q   <= div_d;
            busy_q  <= busy_d;   done_q  <= done_d;     err_q   <= err_d;
            ecode_q <= ecode_d;  ecmd_q  <= ecmd_d;     ctype_q <= ctype_d;
            rca_q   <= rca_d;
        end
    end

    // Next-state: issue/wait/evaluate one command per step, with retries
    always_comb begin
        state_d = state_q;  step_d  = step_q;   retry_d = retry_q;
        poll_d  = poll_q;   to_d    = to_q;     se_d    = se_q;
        resp_d  = resp_q;   start_d = 1'b0;     idx_d   = idx_q;
        arg_d   = arg_q;    pre_d   = pre_q;    div_d   = div_q;
        busy_d  = busy_q;   done_d  = done_q;   err_d   = err_q;
        ecode_d = ecode_q;  ecmd_d  = ecmd_q;   ctype_d = ctype_q;
        rca_d   = rca_q;
        load_cmd = 1'b0;
        go_err   = 1'b0;
        req      = '0;
        retry_step = (step_q == ST_CMD55) || (step_q == ST_CMD2) || (step_q == ST_CMD3) ||
                     (step_q == ST_CMD7)  || (step_q == ST_CMD16);

        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (init_start) begin
                    state_d = S_ISSUE;    step_d  = ST_CMD0;    retry_d = '0;
                    poll_d  = '0;         busy_d  = 1'b1;       done_d  = 1'b0;
                    err_d   = 1'b0;       ecode_d = ERR_NONE;   ecmd_d  = '0;
                    ctype_d = CT_UNKNOWN; rca_d   = '0;         div_d   = SLOW_CLKDIV;
                    load_cmd = 1'b1;
                end
            end
            S_ISSUE: begin
                // cmd_start is registered, so it lands in the first WAIT cycle
                if (!cmd.cmd_busy && !cmd.cmd_done) begin
                    start_d = 1'b1;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cmd.cmd_done) begin
                    to_d    = cmd.cmd_timeout;
                    se_d    = cmd.cmd_syntaxerr;
                    resp_d  = cmd.cmd_resparg;
                    state_d = S_EVAL;
                end
            end
            S_EVAL: begin
                state_d = S_ISSUE;
                if (retry_step && (to_q || se_q)) begin
                    if (retry_q < RETRY_MAX) begin
                        retry_d = retry_q + 1'b1;
                    end else begin
                        go_err  = 1'b1;
                        ecode_d = to_q ? ERR_TIMEOUT : ERR_SYNTAX;
                    end
                end else begin
                    load_cmd = 1'b1;
                    retry_d  = '0;
                    case (step_q)
                        ST_CMD0: step_d = ST_CMD8;
                        ST_CMD8: begin
                            if (to_q) begin
                                ctype_d = CT_SDV1;
                                step_d  = ST_CMD55;
                            end else if (se_q) begin
                                go_err  = 1'b1;
                                ecode_d = ERR_SYNTAX;
                            end else if (resp_q[11:0] == 12'h1AA) begin
                                ctype_d = CT_SDV2;
                                step_d  = ST_CMD55;
                            end else begin
                                go_err  = 1'b1;
                                ecode_d = ERR_CMD8_PATTERN;
                            end
                        end
                        ST_CMD55: step_d = ST_ACMD41;
                        ST_ACMD41: begin
                            // a timed-out poll is just another not-ready answer
                            if (!to_q && !se_q && resp_q[31]) begin
                                if (ctype_q == CT_SDV2 && resp_q[30])
                                    ctype_d = CT_SDHC;
                                step_d = ST_CMD2;
                            end else if (({1'b0, poll_q} + 11'd1) >= POLL_MAX) begin
                                go_err  = 1'b1;
                                ecode_d = ERR_ACMD41_BUSY;
                            end else begin
                                poll_d = poll_q + 10'd1;
                                step_d = ST_CMD55;
                            end
                        end
                        ST_CMD2: step_d = ST_CMD3;
                        ST_CMD3: begin
                            rca_d  = resp_q[31:16];
                            step_d = ST_CMD7;
                        end
                        ST_CMD7: begin
                            // high-capacity cards have a fixed 512-byte block
                            if (ctype_q == CT_SDHC) begin
                                state_d  = S_DONE;
                                load_cmd = 1'b0;
                            end else begin
                                step_d = ST_CMD16;
                            end
                        end
                        ST_CMD16: begin
                            state_d  = S_DONE;
                            load_cmd = 1'b0;
                        end
                        default: ;
                    endcase
                    if (state_d == S_DONE) begin
                        busy_d = 1'b0;
                        done_d = 1'b1;
                        div_d  = FAST_CLKDIV;
                    end
                end
                if (go_err) begin
                    state_d  = S_ERROR;
                    load_cmd = 1'b0;
                    busy_d   = 1'b0;
                    err_d    = 1'b1;
                    ecmd_d   = idx_q;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (load_cmd) begin
            req   = step_cmd(step_d, ctype_d, rca_d);
            idx_d = req.idx;
            arg_d = req.arg;
            pre_d = req.pre;
        end
    end

    assign cmd.cmd_start     = start_q;
    assign cmd.cmd_idx       = idx_q;
    assign cmd.cmd_arg       = arg_q;
    assign cmd.cmd_precycles = pre_q;
    assign cmd.cmd_clkdiv    = div_q;
    assign init_busy         = busy_q;
    assign init_done         = done_q;
    assign init_err          = err_q;
    assign err_code          = ecode_q;
    assign err_cmd           = ecmd_q;
    assign card_type         = ctype_q;
    assign rca               = rca_q;

endmodule

// File: tb/tb_sd_init_seq.sv
// Directed + randomized bench: a card/engine model answers commands, and a
// reference model derives the expected command list and final status.
module tb_sd_init_seq;

    localparam int          A41_MAX = 4;
    localparam int          RTRY    = 2;
    localparam logic [15:0] SLOW    = 16'd150;
    localparam logic [15:0] FAST    = 16'd2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        init_start = 1'b0;
    logic        init_busy, init_done, init_err;
    logic [2:0]  err_code;
    logic [5:0]  err_cmd;
    logic [1:0]  card_type;
    logic [15:0] rca;

    sd_init_seq_if bus ();

    sd_init_seq #(.SLOW_CLKDIV(SLOW), .FAST_CLKDIV(FAST),
                  .ACMD41_RETRIES(A41_MAX), .CMD_RETRIES(RTRY)) dut (
        .clk(clk), .rst_n(rst_n), .init_start(init_start), .cmd(bus.master),
        .init_busy(init_busy), .init_done(init_done), .init_err(init_err),
        .err_code(err_code), .err_cmd(err_cmd), .card_type(card_type), .rca(rca)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // card scenario knobs
    int          sc_cmd8;      // 0 timeout, 1 good echo, 2 bad echo
    int          sc_notready;  // not-ready ACMD41 answers before ready
    logic        sc_hcs;
    logic [15:0] sc_rca;
    logic        sc_cmd2_se;
    logic        sc_fixed;     // use the literal example ACMD41 words
    int          a41_seen;

    // engine-side log
    logic [5:0]  log_idx[$];
    logic [31:0] log_arg[$];
    logic [15:0] log_pre[$];
    logic [15:0] log_div[$];
    int          start_viol = 0;
    int          stab_viol  = 0;

    // expectations
    logic [5:0]  exp_idx[$];
    logic [31:0] exp_arg[$];
    logic [15:0] exp_pre[$];
    logic        e_done, e_err;
    logic [2:0]  e_code;
    logic [5:0]  e_cmd;
    logic [1:0]  e_type;
    logic [15:0] e_rca;

    task automatic check(input string tag, input logic [69:0] obs, input logic [69:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // card answers for the command that just completed
    task automatic respond(input logic [5:0] idx);
        logic [31:0] r;
        r = $urandom;
        bus.cmd_resparg = r;
        case (idx)
            6'd0: bus.cmd_timeout = 1'b1;
            6'd8: begin
                if (sc_cmd8 == 0) bus.cmd_timeout = 1'b1;
                else if (sc_cmd8 == 1) bus.cmd_resparg = {r[31:12], 12'h1AA};
                else bus.cmd_resparg = {r[31:12], 12'h1A5};
            end
            6'd55: bus.cmd_resparg = 32'h0000_0120;
            6'd41: begin
                if (a41_seen < sc_notready) begin
                    if (sc_fixed) bus.cmd_resparg = 32'h00FF_8000;
                    else if ($urandom_range(0, 3) == 0) bus.cmd_timeout = 1'b1;
                    else bus.cmd_resparg = {1'b0, r[30:0]};
                end else begin
                    bus.cmd_resparg = sc_fixed ? 32'hC0FF_8000 : {1'b1, sc_hcs, r[29:0]};
                end
                a41_seen++;
            end
            6'd2: bus.cmd_syntaxerr = sc_cmd2_se;
            6'd3: bus.cmd_resparg = {sc_rca, 16'h0520};
            default: ;
        endcase
    endtask

    // engine model: random latency, busy while active, one-cycle done
    initial begin : engine
        int cnt;
        logic [69:0] snap;
        logic [5:0]  cur;
        cnt = 0; snap = '0; cur = '0;
        bus.cmd_busy = 1'b0; bus.cmd_done = 1'b0; bus.cmd_timeout = 1'b0;
        bus.cmd_syntaxerr = 1'b0; bus.cmd_resparg = '0;
        forever begin
            @(negedge clk);
            bus.cmd_done = 1'b0; bus.cmd_timeout = 1'b0; bus.cmd_syntaxerr = 1'b0;
            if (!rst_n) begin
                cnt = 0;
                bus.cmd_busy = 1'b0;
            end else if (cnt > 0) begin
                if (bus.cmd_start) start_viol++;
                cnt--;
                if (cnt == 0) begin
                    if ({bus.cmd_idx, bus.cmd_arg, bus.cmd_precycles, bus.cmd_clkdiv} !== snap)
                        stab_viol++;
                    bus.cmd_busy = 1'b0;
                    bus.cmd_done = 1'b1;
                    respond(cur);
                end
            end else if (bus.cmd_start) begin
                log_idx.push_back(bus.cmd_idx);
                log_arg.push_back(bus.cmd_arg);
                log_pre.push_back(bus.cmd_precycles);
                log_div.push_back(bus.cmd_clkdiv);
                snap = {bus.cmd_idx, bus.cmd_arg, bus.cmd_precycles, bus.cmd_clkdiv};
                cur = bus.cmd_idx;
                bus.cmd_busy = 1'b1;
                cnt = $urandom_range(2, 6);
            end
        end
    end

    task automatic push(input int idx, input logic [31:0] arg);
        exp_idx.push_back(6'(idx));
        exp_arg.push_back(arg);
        exp_pre.push_back((idx == 0) ? 16'd80 : 16'd8);
    endtask

    // reference: walk the identification rules for the configured card
    task automatic build_model();
        int t;
        logic [31:0] a41;
        exp_idx.delete(); exp_arg.delete(); exp_pre.delete();
        e_done = 0; e_err = 0; e_code = 0; e_cmd = 0; e_type = 0; e_rca = 0;
        push(0, 0);
        push(8, 32'h1AA);
        if (sc_cmd8 == 2) begin e_err = 1; e_code = 1; e_cmd = 8; return; end
        t = (sc_cmd8 == 0) ? 1 : 2;
        e_type = 2'(t);
        a41 = (t == 1) ? 32'h00FF_8000 : 32'h40FF_8000;
        for (int p = 0; p < 2000; p++) begin
            push(55, 0);
            push(41, a41);
            if (p >= sc_notready) break;
            if (p + 1 >= A41_MAX) begin e_err = 1; e_code = 2; e_cmd = 41; return; end
        end
        if (t == 2 && (sc_hcs || sc_fixed)) e_type = 2'd3;
        if (sc_cmd2_se) begin
            for (int k = 0; k <= RTRY; k++) push(2, 0);
            e_err = 1; e_code = 4; e_cmd = 2; return;
        end
        push(2, 0);
        push(3, 0);
        e_rca = sc_rca;
        push(7, {sc_rca, 16'h0});
        if (e_type != 2'd3) push(16, 512);
        e_done = 1;
    endtask

    task automatic set_card(input int c8, input int nr, input logic hcs,
                            input logic [15:0] r, input logic se, input logic fx);
        sc_cmd8 = c8; sc_notready = nr; sc_hcs = hcs; sc_rca = r;
        sc_cmd2_se = se; sc_fixed = fx; a41_seen = 0;
        log_idx.delete(); log_arg.delete(); log_pre.delete(); log_div.delete();
    endtask

    task automatic run_card(input string name);
        int cyc;
        int n;
        build_model();
        @(negedge clk) init_start = 1'b1;
        @(negedge clk) init_start = 1'b0;
        check({name, ".busy_rise"}, {68'd0, init_busy, bus.cmd_start}, 70'b10);
        repeat (3) @(negedge clk);
        init_start = 1'b1;                    // must be ignored while busy
        @(negedge clk) init_start = 1'b0;
        cyc = 0;
        while (!(init_done || init_err) && cyc < 20000) begin
            @(negedge clk);
            cyc++;
        end
        check({name, ".finished"}, 70'(init_done || init_err), 70'd1);
        check({name, ".busy_fall"}, 70'(init_busy), 70'd0);
        repeat (20) @(negedge clk);
        check({name, ".ncmds"}, 70'(log_idx.size()), 70'(exp_idx.size()));
        n = (log_idx.size() < exp_idx.size()) ? log_idx.size() : exp_idx.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s.cmd%0d", name, i), {log_idx[i], log_arg[i], log_pre[i]},
                  {exp_idx[i], exp_arg[i], exp_pre[i]});
            check($sformatf("%s.div%0d", name, i), 70'(log_div[i]), 70'(SLOW));
        end
        check({name, ".status"}, {init_done, init_err, err_code, err_cmd},
              {e_done, e_err, e_code, e_cmd});
        check({name, ".type_rca"}, {card_type, rca}, {e_type, e_rca});
        check({name, ".clkdiv"}, 70'(bus.cmd_clkdiv), 70'(e_done ? FAST : SLOW));
    endtask

    task automatic check_reset_vals(input string name);
        check({name, ".ctl"}, {bus.cmd_start, init_busy, init_done, init_err}, 70'd0);
        check({name, ".info"}, {err_code, err_cmd, card_type, rca}, 70'd0);
        check({name, ".cmd"}, {bus.cmd_idx, bus.cmd_arg, bus.cmd_precycles, bus.cmd_clkdiv},
              {6'd0, 32'd0, 16'd80, SLOW});
    endtask

    initial begin : main
        int cyc;
        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        set_card(1, 2, 1'b1, 16'hAAAA, 1'b0, 1'b1);
        run_card("sdhc");

        set_card(0, $urandom_range(0, 3), 1'($urandom), 16'($urandom), 1'b0, 1'b0);
        run_card("sdv1");

        set_card(2, 0, 1'b0, 16'h1234, 1'b0, 1'b0);
        run_card("cmd8_bad");

        set_card(1, 100, 1'b1, 16'h1234, 1'b0, 1'b0);
        run_card("a41_never");

        set_card(1, 0, 1'b0, 16'h5555, 1'b1, 1'b0);
        run_card("cmd2_syntax");

        for (int k = 0; k < 3; k++) begin
            set_card(1, $urandom_range(0, 3), 1'b0, 16'($urandom), 1'b0, 1'b0);
            run_card($sformatf("sdv2_rand%0d", k));
        end

        // reset while an ACMD41 is in flight, then a clean rerun
        set_card(1, 3, 1'b1, 16'hAAAA, 1'b0, 1'b1);
        @(negedge clk) init_start = 1'b1;
        @(negedge clk) init_start = 1'b0;
        cyc = 0;
        while (!(log_idx.size() > 0 && log_idx[log_idx.size()-1] == 6'd41) && cyc < 5000) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        check("rst.reached_a41", 70'(cyc < 5000), 70'd1);
        #2 rst_n = 1'b0;
        #1 check_reset_vals("rst_mid");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        set_card(1, 2, 1'b1, 16'hAAAA, 1'b0, 1'b1);
        run_card("rst_rerun");

        check("no_start_while_busy", 70'(start_viol), 70'd0);
        check("cmd_regs_stable", 70'(stab_viol), 70'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sd_init_seq.md
# sd_init_seq

SD-card initialisation sequencer that sits directly above the 1-bit SD CMD-line command engine and drives its start/cmd/arg/clkdiv/precycles inputs. On request it walks the card through identification (CMD0, CMD8, CMD55/ACMD41 polling, CMD2, CMD3, CMD7, optional CMD16) at the slow identification clock. It reports card type and RCA, then switches the engine to the fast transfer clock divider. Data-line controllers start only after `init_done`.

## Interface
- `SLOW_CLKDIV`, 16'd150: engine clkdiv during identification (≤400 kHz SDCLK).
- `FAST_CLKDIV`, 16'd2: engine clkdiv after successful init.
- `ACMD41_RETRIES`, 1023: maximum CMD55+ACMD41 pairs before giving up.
- `CMD_RETRIES`, 3: retries after timeout/syntax error for CMD2/3/7/16/55 (attempts = CMD_RETRIES+1).

Ports:
- `clk` in 1: system clock (shared with the engine).
- `rst_n` in 1: asynchronous, active-low reset.
- `init_start` in 1: one-cycle request; ignored while `init_busy`.
- `cmd_start` out 1: one-cycle start pulse to the engine.
- `cmd_precycles` out 16: idle SDCLK cycles before the command.
- `cmd_clkdiv` out 16: SDCLK divider.
- `cmd_idx` out 6: command index.
- `cmd_arg` out 32: command argument.
- `cmd_resparg` in 32: engine response argument (bits 127:96 of the long response).
- `cmd_busy`, `cmd_done`, `cmd_timeout`, `cmd_syntaxerr` in 1 each: engine status.
- `init_busy`, `init_done`, `init_err` out 1 each: sequencer status; done and err are levels.
- `err_code` out 3: 0 none, 1 CMD8 pattern mismatch, 2 ACMD41 not ready, 3 command timeout, 4 response syntax error.
- `err_cmd` out 6: index of the failing command.
- `card_type` out 2: 0 unknown, 1 SDv1, 2 SDv2 standard capacity, 3 SDHC/SDXC.
- `rca` out 16: relative card address.

## Operation
- States: IDLE, ISSUE, WAIT, EVAL, DONE, ERROR. A step register selects the command: CMD0, CMD8, CMD55, ACMD41, CMD2, CMD3, CMD7, CMD16.
- ISSUE: waits for `cmd_busy`=0, drives idx/arg/precycles, then pulses `cmd_start` for one cycle and moves to WAIT. WAIT exits on the cycle `cmd_done`=1; timeout, syntaxerr and resparg are latched in that same cycle.
- CMD0, arg 0, precycles 80: has no response, so a timeout is success. Next step: CMD8.
- CMD8, arg 0x0000_01AA:
  - timeout → `card_type`=1 (SDv1), next CMD55;
  - resparg[11:0]==12'h1AA → `card_type`=2, next CMD55;
  - any other response → ERROR code 1;
  - syntaxerr → ERROR code 4.
- CMD55, arg 0, then ACMD41 with arg 0x40FF_8000 (type≥2) or 0x00FF_8000 (type 1):
  - resparg[31]=1 → ready; resparg[30]=1 with type 2 sets type 3. Next CMD2.
  - otherwise the poll counter increments and the sequencer repeats CMD55. At `ACMD41_RETRIES` pairs it enters ERROR code 2.
  - ACMD41 timeout counts as a not-ready poll.
- CMD2, arg 0 (long response). Next CMD3, arg 0: `rca`←resparg[31:16]. Next CMD7, arg {rca,16'h0}. Next CMD16, arg 512, issued only when type≠3; otherwise go straight to DONE.
- Retry rule (CMD55/2/3/7/16): on timeout or syntaxerr, reissue while the retry count < `CMD_RETRIES`. Once exhausted, ERROR with code 3 or 4 and `err_cmd`=index. The retry counter clears when the step advances.
- Precycles are 8 for every command except CMD0.
- DONE: `cmd_clkdiv`←`FAST_CLKDIV`, `init_done`=1.
- ERROR: `init_err`=1, `cmd_clkdiv` stays slow.
- From DONE or ERROR, `init_start` restarts from CMD0. The restart clears done, err, err_code, err_cmd, card_type and rca, and restores `SLOW_CLKDIV`.

## Timing
- Reset values:
  - `cmd_start`, `init_busy`, `init_done`, `init_err` = 0;
  - `err_code`, `err_cmd`, `card_type`, `rca`, `cmd_idx`, `cmd_arg` = 0;
  - `cmd_precycles`=80, `cmd_clkdiv`=`SLOW_CLKDIV`;
  - state IDLE.
- `init_start` → `init_busy`=1 next cycle. The first `cmd_start` follows no earlier than 1 cycle later.
- `cmd_idx`, `cmd_arg`, `cmd_precycles`, `cmd_clkdiv` are registered and stable from one cycle before `cmd_start` until after `cmd_done`.
- Never pulse `cmd_start` while `cmd_busy`=1, or in the cycle `cmd_done`=1.
- `cmd_done` is high for one cycle. EVAL takes one cycle, so the minimum gap from done to the next start is 2 cycles.
- `init_busy` falls in the same cycle `init_done` or `init_err` rises.
- `rst_n` mid-sequence returns everything to reset values immediately (the engine shares `rst_n`). No partial state survives.
- `init_start` while busy has no effect.

## Structure
- Shared package `sd_pkg`:
  - command index constants (CMD0, 2, 3, 7, 8, 16, 55, ACMD41);
  - `card_type_t` and `init_err_t` enums;
  - constants CMD8_ARG, ACMD41_ARG_HCS and ACMD41_ARG_SC.
- No sub-module. One FSM plus step, retry (log2 of `CMD_RETRIES`+1) and poll (10-bit) counters.

## Test plan
- SDHC card model: CMD0 times out, CMD8 returns 0x0000_01AA, ACMD41 returns 0x00FF_8000 twice then 0xC0FF_8000, CMD3 returns 0xAAAA_0520 → `init_done`, `card_type`=3, `rca`=0xAAAA, CMD7 arg 0xAAAA_0000, no CMD16, `cmd_clkdiv`=`FAST_CLKDIV`.
- SDv1 model: CMD8 times out → ACMD41 arg 0x00FF_8000, CMD16 arg 0x200 issued, `card_type`=1, `init_done`.
- CMD8 returns 0x0000_01A5 → `init_err`, `err_code`=1, `err_cmd`=8, no further `cmd_start`.
- ACMD41 never ready, `ACMD41_RETRIES`=4 → exactly 4 CMD55/ACMD41 pairs, then `err_code`=2.
- CMD2 raises `cmd_syntaxerr` every time, `CMD_RETRIES`=2 → 3 CMD2 attempts, then `err_code`=4, `err_cmd`=2.
- `rst_n` low during ACMD41 WAIT → all outputs at reset values. Afterwards `init_start` reruns from CMD0 with precycles 80 and completes (scenario-1 model).
